fc_stream_arbiter: RTL

FC_STREAM_ARBITER -- requirements
Module: fc_stream_arbiter

---
 rtl/fc_stream_arbiter.sv | 81 ++++++++
 1 files changed

// File: rtl/fc_stream_arbiter.sv
// fc_stream_arbiter: round-robin share of one fc engine between requesters r0/r1; each job is N_IN x beats in (FEED), N_OUT y beats back (DRAIN); grant one-hot owner, busy when not IDLE
module fc_stream_arbiter #(
  parameter int WIDTH = 8,
  parameter int N_IN  = 6,
  parameter int N_OUT = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             r0_input_valid,
  output logic             r0_input_ready,
  input  logic [WIDTH-1:0] r0_input_data,
  input  logic             r1_input_valid,
  output logic             r1_input_ready,
  input  logic [WIDTH-1:0] r1_input_data,
  output logic             r0_output_valid,
  input  logic             r0_output_ready,
  output logic [WIDTH-1:0] r0_output_data,
  output logic             r1_output_valid,
  input  logic             r1_output_ready,
  output logic [WIDTH-1:0] r1_output_data,
  output logic             eng_input_valid,
  input  logic             eng_input_ready,
  output logic [WIDTH-1:0] eng_input_data,
  input  logic             eng_output_valid,
  output logic             eng_output_ready,
  input  logic [WIDTH-1:0] eng_output_data,
  output logic [1:0]       grant,
  output logic             busy
);
  localparam int CW = $clog2(((N_IN > N_OUT) ? N_IN : N_OUT) + 1);
  typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;
  state_t state;
  logic last;
  logic [CW-1:0] in_cnt, out_cnt;
  logic feed, drain, in_fire, out_fire;
  always_comb begin
    feed = state == FEED && !reset;
    drain = state == DRAIN && !reset;
    eng_input_valid = feed && (grant[0] ? r0_input_valid : r1_input_valid);
    eng_input_data = feed ? (grant[0] ? r0_input_data : r1_input_data) : '0;
    r0_input_ready = feed && grant[0] && eng_input_ready;
    r1_input_ready = feed && grant[1] && eng_input_ready;
    eng_output_ready = drain && (grant[0] ? r0_output_ready : r1_output_ready);
    r0_output_valid = drain && grant[0] && eng_output_valid;
    r1_output_valid = drain && grant[1] && eng_output_valid;
    r0_output_data = (drain && grant[0]) ? eng_output_data : '0;
    r1_output_data = (drain && grant[1]) ? eng_output_data : '0;
    in_fire = eng_input_valid && eng_input_ready;
    out_fire = eng_output_valid && eng_output_ready;
    busy = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      in_cnt <= '0;
      out_cnt <= '0;
      last <= 1'b1;
    end else begin
      case (state)
        IDLE: if (r0_input_valid || r1_input_valid) begin
          grant <= (r0_input_valid && (!r1_input_valid || last)) ? 2'b01 : 2'b10;
          state <= FEED;
        end
        FEED: if (in_fire) begin
          in_cnt <= (in_cnt == CW'(N_IN - 1)) ? '0 : in_cnt + CW'(1);
          if (in_cnt == CW'(N_IN - 1)) state <= DRAIN;
        end
        DRAIN: if (out_fire) begin
          out_cnt <= (out_cnt == CW'(N_OUT - 1)) ? '0 : out_cnt + CW'(1);
          if (out_cnt == CW'(N_OUT - 1)) begin
            last <= grant[1];
            grant <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
